// File: rtl/envelope_sequencer.sv
// Note envelope sequencer: walks the decay-ROM index on sample ticks and forwards decayed samples.
// Build option: define ENVELOPE_ATTACK_EN to add a soft-to-loud ATTACK ramp before DECAY.
module envelope_sequencer #(
   parameter int STEP_TICKS = 1024,
   parameter int TICK_W     = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        note_on,
   input  logic        note_off,
   input  logic        sample_tick,
   input  logic [15:0] decayed_sample,
   input  logic        sample_ready,
   output logic [5:0]  duration,
   output logic [15:0] env_sample,
   output logic        env_valid,
   output logic        busy,
   output logic        note_done
);

   // state  | meaning
   // IDLE   | no note; outputs held at zero, ticks and samples ignored
   // ATTACK | ramping index 63 -> 0 (only with ENVELOPE_ATTACK_EN)
   // DECAY  | ramping index 0 -> 63, then note finishes
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
`ifdef ENVELOPE_ATTACK_EN
      ATTACK = 2'd1,
`endif
      DECAY  = 2'd2
   } state_t;

`ifdef ENVELOPE_ATTACK_EN
   localparam state_t     START_STATE = ATTACK;
   localparam logic [5:0] START_DUR   = 6'd63;
`else
   localparam state_t     START_STATE = DECAY;
   localparam logic [5:0] START_DUR   = 6'd0;
`endif

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_TICKS - 1);

   state_t            state;
   logic [TICK_W-1:0] tick_cnt;
   logic              step;

   assign step = sample_tick && (tick_cnt == TICK_LAST);
   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         tick_cnt   <= '0;
         duration   <= 6'd0;
         env_sample <= 16'd0;
         env_valid  <= 1'b0;
         note_done  <= 1'b0;
      end else begin
         env_valid <= 1'b0;
         note_done <= 1'b0;
         if (note_on) begin
            // a coincident tick is dropped so the new note starts from a clean count
            state    <= START_STATE;
            tick_cnt <= '0;
            duration <= START_DUR;
         end else if (state != IDLE) begin
            if (note_off) begin
               state      <= IDLE;
               tick_cnt   <= '0;
               duration   <= 6'd0;
               env_sample <= 16'd0;
            end else begin
               if (sample_tick) begin
                  tick_cnt <= step ? '0 : tick_cnt + TICK_W'(1);
               end
               if (sample_ready) begin
                  env_sample <= decayed_sample;
                  env_valid  <= 1'b1;
               end
               if (step) begin
                  case (state)
                     DECAY: begin
                        if (duration == 6'd63) begin
                           // natural end overrides any sample arriving this cycle
                           state      <= IDLE;
                           tick_cnt   <= '0;
                           duration   <= 6'd0;
                           env_sample <= 16'd0;
                           env_valid  <= 1'b0;
                           note_done  <= 1'b1;
                        end else begin
                           duration <= duration + 6'd1;
                        end
                     end
`ifdef ENVELOPE_ATTACK_EN
                     ATTACK: begin
                        if (duration == 6'd0) begin
                           state <= DECAY;
                        end else begin
                           duration <= duration - 6'd1;
                        end
                     end
`endif
                     default: ;
                  endcase
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_envelope_sequencer.sv
// Self-checking bench for envelope_sequencer (STEP_TICKS=4); follows ENVELOPE_ATTACK_EN if defined.
module tb_envelope_sequencer;

   localparam int STEP = 4;
`ifdef ENVELOPE_ATTACK_EN
   localparam int START_DUR  = 63;
   localparam int START_ST   = 1;
   localparam int NOTE_TICKS = 512;
   localparam int FIRST_STEP = 62;
`else
   localparam int START_DUR  = 0;
   localparam int START_ST   = 2;
   localparam int NOTE_TICKS = 256;
   localparam int FIRST_STEP = 1;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        note_on = 1'b0;
   logic        note_off = 1'b0;
   logic        sample_tick = 1'b0;
   logic [15:0] decayed_sample = 16'd0;
   logic        sample_ready = 1'b0;
   logic [5:0]  duration;
   logic [15:0] env_sample;
   logic        env_valid;
   logic        busy;
   logic        note_done;

   int n_checks = 0;
   int n_fail   = 0;

   int          dur_q[$];
   logic [15:0] env_q[$];

   // reference model: 0 idle, 1 attack, 2 decay
   int          m_state = 0;
   int          m_cnt   = 0;
   int          m_dur   = 0;
   logic [15:0] m_env   = 16'd0;
   logic        m_done  = 1'b0;
   logic        m_valid = 1'b0;
   logic [5:0]  prev_dur = 6'd0;

   envelope_sequencer #(.STEP_TICKS(STEP), .TICK_W(16)) dut (
      .clk(clk), .reset(reset), .note_on(note_on), .note_off(note_off),
      .sample_tick(sample_tick), .decayed_sample(decayed_sample),
      .sample_ready(sample_ready), .duration(duration), .env_sample(env_sample),
      .env_valid(env_valid), .busy(busy), .note_done(note_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      int          e;
      logic [15:0] e16;
      if (!reset) begin
         prev_dur = duration;
      end else begin
         if (duration !== prev_dur) begin
            n_checks++;
            if (dur_q.size() == 0) begin
               n_fail++;
               $display("FAIL dur_change: got %0d, no change expected", duration);
            end else begin
               e = dur_q.pop_front();
               if (duration !== 6'(e)) begin
                  n_fail++;
                  $display("FAIL dur_seq: got %0d, expected %0d", duration, e);
               end
            end
            prev_dur = duration;
         end
         if (env_valid === 1'b1) begin
            n_checks++;
            if (env_q.size() == 0) begin
               n_fail++;
               $display("FAIL env_unexpected: env_valid with sample %h", env_sample);
            end else begin
               e16 = env_q.pop_front();
               if (env_sample !== e16) begin
                  n_fail++;
                  $display("FAIL env_sample: got %h, expected %h", env_sample, e16);
               end
            end
         end
      end
   end

   task automatic set_dur(input int d);
      if (d != m_dur) dur_q.push_back(d);
      m_dur = d;
   endtask

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_dur = 0; m_env = 16'd0; m_done = 1'b0; m_valid = 1'b0;
      dur_q.delete();
      env_q.delete();
   endtask

   // updates the model, drives one cycle of inputs, returns at posedge+1
   task automatic apply(input logic on, input logic off, input logic tick,
                        input logic rdy, input logic [15:0] data);
      m_done  = 1'b0;
      m_valid = 1'b0;
      if (on) begin
         m_cnt   = 0;
         m_state = START_ST;
         set_dur(START_DUR);
      end else if (m_state != 0) begin
         if (off) begin
            m_state = 0; m_cnt = 0; m_env = 16'd0;
            set_dur(0);
         end else begin
            if (tick) begin
               if (m_cnt == STEP - 1) begin
                  m_cnt = 0;
                  if (m_state == 2) begin
                     if (m_dur < 63) set_dur(m_dur + 1);
                     else begin
                        m_state = 0; m_env = 16'd0; m_done = 1'b1;
                        set_dur(0);
                     end
                  end else begin
                     if (m_dur > 0) set_dur(m_dur - 1);
                     else m_state = 2;
                  end
               end else begin
                  m_cnt++;
               end
            end
            if (rdy && m_state != 0) begin
               m_env = data; m_valid = 1'b1;
               env_q.push_back(data);
            end
         end
      end
      note_on = on; note_off = off; sample_tick = tick;
      sample_ready = rdy; decayed_sample = data;
      @(posedge clk);
      #1;
      note_on = 1'b0; note_off = 1'b0; sample_tick = 1'b0;
      sample_ready = 1'b0; decayed_sample = 16'd0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (duration !== 6'd0) begin n_fail++; $display("FAIL rst_duration: got %0d, expected 0", duration); end
      n_checks++; if (env_sample !== 16'd0) begin n_fail++; $display("FAIL rst_env: got %h, expected 0", env_sample); end
      n_checks++; if (env_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", env_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, expected 0", busy); end
      n_checks++; if (note_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, expected 0", note_done); end
      reset = 1'b1;
      model_reset();
      apply(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_first_note: busy %b, expected 1", busy); end
      n_checks++; if (duration !== 6'(START_DUR)) begin n_fail++; $display("FAIL rst_first_dur: got %0d, expected %0d", duration, START_DUR); end
      apply(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
   endtask

   task automatic test_note_full();
      apply(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
      for (int i = 0; i < NOTE_TICKS; i++) begin
         // on the final tick a coincident sample must be dropped
         apply(1'b0, 1'b0, 1'b1, (i == NOTE_TICKS - 1), 16'h7777);
         n_checks++;
         if (note_done !== (i == NOTE_TICKS - 1)) begin
            n_fail++; $display("FAIL note_done tick %0d: got %b, expected %b", i + 1, note_done, (i == NOTE_TICKS - 1));
         end
         n_checks++;
         if (busy !== (i != NOTE_TICKS - 1)) begin
            n_fail++; $display("FAIL note_busy tick %0d: got %b, expected %b", i + 1, busy, (i != NOTE_TICKS - 1));
         end
      end
      n_checks++; if (env_valid !== 1'b0 || env_sample !== 16'd0) begin n_fail++; $display("FAIL end_drop: valid %b env %h, expected 0 0000", env_valid, env_sample); end
      n_checks++; if (duration !== 6'd0) begin n_fail++; $display("FAIL end_dur: got %0d, expected 0", duration); end
      apply(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      n_checks++; if (note_done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b, expected 0", note_done); end
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      apply(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
      while (!(m_state == 2 && m_dur == 17) && guard < 600) begin
         apply(1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
         guard++;
      end
      n_checks++; if (guard >= 600) begin n_fail++; $display("FAIL mid_reach: duration %0d, expected 17", duration); end
      apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);
      #2 reset = 1'b0;
      #1;
      n_checks++; if (duration !== 6'd0) begin n_fail++; $display("FAIL mid_rst_dur: got %0d, expected 0", duration); end
      n_checks++; if (env_sample !== 16'd0) begin n_fail++; $display("FAIL mid_rst_env: got %h, expected 0", env_sample); end
      n_checks++; if (env_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b, expected 0", env_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b, expected 0", busy); end
      model_reset();
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_idle: busy %b, expected 0", busy); end
   endtask

   task automatic test_sample_ready();
      apply(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
      apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h8001);
      n_checks++; if (env_valid !== 1'b1) begin n_fail++; $display("FAIL sr_valid: got %b, expected 1", env_valid); end
      n_checks++; if (env_sample !== 16'h8001) begin n_fail++; $display("FAIL sr_env: got %h, expected 8001", env_sample); end
      apply(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      n_checks++; if (env_valid !== 1'b0) begin n_fail++; $display("FAIL sr_pulse: got %b, expected 0", env_valid); end
      n_checks++; if (env_sample !== 16'h8001) begin n_fail++; $display("FAIL sr_hold: got %h, expected 8001", env_sample); end
      apply(1'b0, 1'b1, 1'b0, 1'b1, 16'h4321);
      n_checks++; if (env_valid !== 1'b0 || env_sample !== 16'd0) begin n_fail++; $display("FAIL sr_off_drop: valid %b env %h, expected 0 0000", env_valid, env_sample); end
      apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h8001);
      n_checks++; if (env_valid !== 1'b0 || env_sample !== 16'd0) begin n_fail++; $display("FAIL sr_idle: valid %b env %h, expected 0 0000", env_valid, env_sample); end
   endtask

   task automatic test_restart();
      int guard = 0;
      apply(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
      while (m_dur != 40 && guard < 600) begin
         apply(1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
         guard++;
      end
      n_checks++; if (duration !== 6'd40) begin n_fail++; $display("FAIL rs_reach: got %0d, expected 40", duration); end
      apply(1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rs_busy: got %b, expected 1", busy); end
      n_checks++; if (duration !== 6'(START_DUR)) begin n_fail++; $display("FAIL rs_dur: got %0d, expected %0d", duration, START_DUR); end
      repeat (5) apply(1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
      apply(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL off_busy: got %b, expected 0", busy); end
      n_checks++; if (note_done !== 1'b0) begin n_fail++; $display("FAIL off_done: got %b, expected 0", note_done); end
      n_checks++; if (duration !== 6'd0) begin n_fail++; $display("FAIL off_dur: got %0d, expected 0", duration); end
   endtask

   task automatic test_tick_coincident();
      apply(1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
      for (int i = 0; i < STEP - 1; i++) begin
         apply(1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
         n_checks++;
         if (duration !== 6'(START_DUR)) begin
            n_fail++; $display("FAIL tc_early tick %0d: got %0d, expected %0d", i + 1, duration, START_DUR);
         end
      end
      apply(1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
      n_checks++; if (duration !== 6'(FIRST_STEP)) begin n_fail++; $display("FAIL tc_step: got %0d, expected %0d", duration, FIRST_STEP); end
      apply(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
   endtask

   initial begin
      test_reset();
      test_note_full();
      test_reset_mid();
      test_sample_ready();
      test_restart();
      test_tick_coincident();
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (dur_q.size() != 0) begin n_fail++; $display("FAIL dur_pending: %0d changes outstanding, expected 0", dur_q.size()); end
      n_checks++; if (env_q.size() != 0) begin n_fail++; $display("FAIL env_pending: %0d samples outstanding, expected 0", env_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/envelope_sequencer.md
ENVELOPE_SEQUENCER -- requirements
Module: envelope_sequencer

Interface
REQ-001 SHALL have parameter STEP_TICKS, default 1024: sample_tick pulses per duration-index step, legal range 1..65535.
REQ-002 SHALL have parameter TICK_W, default 16: width of the internal tick counter, which SHALL hold STEP_TICKS-1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 note_on  input  1  one-cycle pulse; start or restart a note.
REQ-006 note_off  input  1  one-cycle pulse; abort the active note.
REQ-007 sample_tick  input  1  one-cycle pulse per audio sample period.
REQ-008 decayed_sample  input  16  signed sample returned by the decay multiplier.
REQ-009 sample_ready  input  1  decayed_sample changed this cycle.
REQ-010 duration  output  6  registered envelope index driven to the decay ROM.
REQ-011 env_sample  output  16  registered signed enveloped sample.
REQ-012 env_valid  output  1  one-cycle pulse; env_sample updated.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 note_done  output  1  one-cycle pulse; note finished naturally.

Function
REQ-015 SHALL implement states IDLE, ATTACK (only when ATTACK_EN is defined) and DECAY.
REQ-016 IDLE: duration=0, env_sample=0, env_valid=0; sample_ready and sample_tick ignored.
REQ-017 note_on in any state SHALL clear tick count, enter the start state (REQ-029/030) next cycle and load its start duration.
REQ-018 note_on and note_off in the same cycle: note_on wins.
REQ-019 note_on and sample_tick in the same cycle: the tick is discarded.
REQ-020 note_off without note_on in ATTACK/DECAY: enter IDLE next cycle, env_sample->0, no note_done, no env_valid.
REQ-021 Each sample_tick in ATTACK/DECAY increments the tick count; when it equals STEP_TICKS-1 it wraps to 0 and a step occurs in the same cycle.
REQ-022 DECAY step: duration<63 -> duration+1 next cycle; duration==63 -> IDLE next cycle with note_done=1 for exactly that cycle.
REQ-023 ATTACK step: duration>0 -> duration-1 next cycle; duration==0 -> DECAY next cycle, duration stays 0.
REQ-024 In ATTACK/DECAY, sample_ready=1 SHALL latch decayed_sample into env_sample and assert env_valid the following cycle (latency 1).
REQ-025 sample_ready in the same cycle as a DECAY->IDLE transition or note_off SHALL be dropped (IDLE output wins).
REQ-026 duration SHALL change only on step, note_on or IDLE entry; never glitch between.
REQ-027 With STEP_TICKS=1 every sample_tick SHALL step.

Reset
REQ-028 reset low SHALL immediately force IDLE, tick count=0, duration=0, env_sample=0, env_valid=0, busy=0, note_done=0, including mid-note; release is synchronous to clk, first note_on accepted on the first edge after release.

Configuration
REQ-029 Macro ENVELOPE_ATTACK_EN defined: note_on enters ATTACK with duration=63 (soft-to-loud ramp), then DECAY per REQ-023.
REQ-030 Macro ENVELOPE_ATTACK_EN undefined: ATTACK state absent; note_on enters DECAY with duration=0; all other behaviour identical.

Verification (bench STEP_TICKS=4)
REQ-031 Reset mid-DECAY at duration=17 -> all outputs 0 asynchronously, busy=0 before next clk edge.
REQ-032 No ATTACK_EN: note_on then 256 sample_ticks -> duration 0,1,..,63 every 4 ticks; note_done single pulse after tick 256; busy falls same cycle.
REQ-033 ATTACK_EN: note_on then 256 ticks -> duration 63 down to 0, then DECAY from 0; total note length 512 ticks.
REQ-034 sample_ready with decayed_sample=16'h8001 in DECAY -> env_sample=16'h8001, env_valid high exactly one cycle later; same stimulus in IDLE -> env_sample stays 0.
REQ-035 note_on+note_off same cycle at duration=40 -> restart at start duration, busy stays 1; note_off alone -> IDLE, no note_done.
REQ-036 note_on coincident with sample_tick -> tick count 0; first step requires 4 further ticks.
